// File: rtl/disp_scan_decoder.sv
// disp_scan_decoder
//   Receive side of the 4-digit multiplexed 7-segment scan bus. DISP is registered
//   once. A slot is accepted when its value has been present for STABLE_CYC
//   consecutive samples, and the same run is never accepted twice. Accepted segment
//   patterns are decoded back to digit codes. A 4-digit frame is published once
//   every position has been captured.
//
//   Ports
//     CLK        in   1   system clock, posedge
//     RSTN       in   1   asynchronous reset, active-low
//     DISP       in   12  [11:8] active-low one-hot digit select (bit8 = pos0),
//                         [7] active-low dp, [6:0] active-low segments g..a
//     NUM        out  16  last complete frame, nibble k = digit at pos k
//     DPS        out  4   last complete frame decimal points, 1 = lit
//     FRAME_VLD  out  1   one-cycle pulse when NUM/DPS update
//     SEG_ERR    out  1   sticky bad pattern / bad select flag, cleared by a clean frame
//     STALE      out  1   no one-hot slot accepted for TIMEOUT cycles
//
//   Build option
//     DISP_HEX_EN  when defined, the patterns for A,b,C,d,E,F decode to 4'hA..4'hF;
//                  otherwise they are treated as undecodable.
module disp_scan_decoder #(
    parameter int unsigned STABLE_CYC = 16,
    parameter int unsigned TIMEOUT    = 1000000
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic [11:0] DISP,
    output logic [15:0] NUM,
    output logic [3:0]  DPS,
    output logic        FRAME_VLD,
    output logic        SEG_ERR,
    output logic        STALE
);

    localparam int unsigned CNT_W  = $clog2(STABLE_CYC + 1);
    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [11:0] DISP_IDLE = 12'hFFF;
    localparam logic [CNT_W-1:0]  ACC_CNT  = CNT_W'(STABLE_CYC - 2);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_COUNT = 2'd1,
        S_HELD  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  stab_cnt_q, stab_cnt_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [11:0]       d_q, d_prev_q;
    logic [3:0][3:0]   dig_q, dig_d;
    logic [3:0]        dpb_q, dpb_d;
    logic [3:0]        seen_q, seen_d;
    logic              err_frame_q, err_frame_d;
    logic [15:0]       num_q, num_d;
    logic [3:0]        dps_q, dps_d;
    logic              vld_q, vld_d;
    logic              seg_err_q, seg_err_d;
    logic              stale_q, stale_d;

    logic              accept_c;
    logic              commit_c;
    logic [3:0]        sel_c;
    logic              onehot_c;
    logic              multi_c;
    logic [1:0]        pos_c;
    logic [4:0]        dec_c;

    // Segment pattern (active-high, gfedcba) to {valid, digit}.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        logic [4:0] res;
        res = 5'b0_0000;
        case (seg)
            7'h3F: res = {1'b1, 4'h0};
            7'h06: res = {1'b1, 4'h1};
            7'h5B: res = {1'b1, 4'h2};
            7'h4F: res = {1'b1, 4'h3};
            7'h66: res = {1'b1, 4'h4};
            7'h6D: res = {1'b1, 4'h5};
            7'h7D: res = {1'b1, 4'h6};
            7'h07: res = {1'b1, 4'h7};
            7'h7F: res = {1'b1, 4'h8};
            7'h6F: res = {1'b1, 4'h9};
`ifdef DISP_HEX_EN
            7'h77: res = {1'b1, 4'hA};
            7'h7C: res = {1'b1, 4'hB};
            7'h39: res = {1'b1, 4'hC};
            7'h5E: res = {1'b1, 4'hD};
            7'h79: res = {1'b1, 4'hE};
            7'h71: res = {1'b1, 4'hF};
`else
`endif
            default: res = 5'b0_0000;
        endcase
        return res;
    endfunction

    // State and datapath registers.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q     <= S_WAIT;
            stab_cnt_q  <= '0;
            idle_q      <= '0;
            d_q         <= DISP_IDLE;
            d_prev_q    <= DISP_IDLE;
            dig_q       <= '0;
            dpb_q       <= 4'h0;
            seen_q      <= 4'h0;
            err_frame_q <= 1'b0;
            num_q       <= 16'h0000;
            dps_q       <= 4'h0;
            vld_q       <= 1'b0;
            seg_err_q   <= 1'b0;
            stale_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            stab_cnt_q  <= stab_cnt_d;
            idle_q      <= idle_d;
            d_q         <= DISP;
            d_prev_q    <= d_q;
            dig_q       <= dig_d;
            dpb_q       <= dpb_d;
            seen_q      <= seen_d;
            err_frame_q <= err_frame_d;
            num_q       <= num_d;
            dps_q       <= dps_d;
            vld_q       <= vld_d;
            seg_err_q   <= seg_err_d;
            stale_q     <= stale_d;
        end
    end

    // Settle FSM: any change restarts the count; HELD blocks re-acceptance of the same run.
    // WAIT is the second sample of a run, so acceptance happens when the run reaches STABLE_CYC.
    always_comb begin
        state_d    = state_q;
        stab_cnt_d = stab_cnt_q;
        accept_c   = 1'b0;
        if (d_q != d_prev_q) begin
            state_d    = S_WAIT;
            stab_cnt_d = '0;
        end else begin
            case (state_q)
                S_WAIT, S_COUNT: begin
                    if (stab_cnt_q == ACC_CNT) begin
                        accept_c = 1'b1;
                        state_d  = S_HELD;
                    end else begin
                        stab_cnt_d = stab_cnt_q + CNT_W'(1);
                        state_d    = S_COUNT;
                    end
                end
                S_HELD:  state_d = S_HELD;
                default: state_d = S_WAIT;
            endcase
        end
    end

    // Slot classification of the registered bus.
    always_comb begin
        sel_c    = ~d_q[11:8];
        onehot_c = (sel_c != 4'h0) && ((sel_c & (sel_c - 4'd1)) == 4'h0);
        multi_c  = (sel_c != 4'h0) && !onehot_c;
        dec_c    = seg_decode(~d_q[6:0]);
        case (sel_c)
            4'b0010: pos_c = 2'd1;
            4'b0100: pos_c = 2'd2;
            4'b1000: pos_c = 2'd3;
            default: pos_c = 2'd0;
        endcase
    end

    // Frame assembly, commit, error and idle tracking.
    // Order matters: commit and timeout clear the mask first, so a same-cycle accept lands in the new frame.
    always_comb begin
        dig_d       = dig_q;
        dpb_d       = dpb_q;
        seen_d      = seen_q;
        err_frame_d = err_frame_q;
        num_d       = num_q;
        dps_d       = dps_q;
        seg_err_d   = seg_err_q;
        stale_d     = stale_q;
        idle_d      = idle_q;
        commit_c    = (seen_q == 4'hF);
        vld_d       = commit_c;

        if (commit_c) begin
            num_d       = dig_q;
            dps_d       = dpb_q;
            seen_d      = 4'h0;
            err_frame_d = 1'b0;
            if (!err_frame_q) begin
                seg_err_d = 1'b0;
            end
        end

        if (accept_c && onehot_c) begin
            idle_d  = '0;
            stale_d = 1'b0;
        end else if (idle_q == IDLE_MAX) begin
            stale_d = 1'b1;
            seen_d  = 4'h0;
        end else begin
            idle_d = idle_q + IDLE_W'(1);
        end

        if (accept_c && multi_c) begin
            seg_err_d   = 1'b1;
            err_frame_d = 1'b1;
        end else if (accept_c && onehot_c) begin
            if (dec_c[4]) begin
                // First digit of a frame starts a fresh error window.
                if (seen_d == 4'h0) begin
                    err_frame_d = 1'b0;
                end
                dig_d[pos_c]  = dec_c[3:0];
                dpb_d[pos_c]  = ~d_q[7];
                seen_d[pos_c] = 1'b1;
            end else begin
                seg_err_d   = 1'b1;
                err_frame_d = 1'b1;
            end
        end
    end

    assign NUM       = num_q;
    assign DPS       = dps_q;
    assign FRAME_VLD = vld_q;
    assign SEG_ERR   = seg_err_q;
    assign STALE     = stale_q;

endmodule

// File: tb/tb_disp_scan_decoder.sv
// Bench for disp_scan_decoder: directed scenarios, a vector table of full frames and a
// randomized slot stream, all compared against a behavioural reference model.
module tb_disp_scan_decoder;

    localparam int unsigned STABLE_CYC = 16;
    localparam int unsigned TIMEOUT    = 300;

    logic        clk  = 1'b0;
    logic        rstn = 1'b0;
    logic [11:0] disp = 12'hFFF;
    logic [15:0] num;
    logic [3:0]  dps;
    logic        frame_vld;
    logic        seg_err;
    logic        stale;

    int n_chk   = 0;
    int n_pass  = 0;
    int vld_cnt = 0;
    bit cmp_en  = 1'b0;

    logic [6:0] pat_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    always #5 clk = ~clk;

    disp_scan_decoder #(
        .STABLE_CYC(STABLE_CYC),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .CLK      (clk),
        .RSTN     (rstn),
        .DISP     (disp),
        .NUM      (num),
        .DPS      (dps),
        .FRAME_VLD(frame_vld),
        .SEG_ERR  (seg_err),
        .STALE    (stale)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    function automatic logic [11:0] slot_raw(input int pos, input logic [6:0] seg, input bit dp);
        logic [3:0] oh;
        oh = 4'b0001 << pos;
        return {~oh, ~dp, ~seg};
    endfunction

    function automatic logic [11:0] slot_dig(input int pos, input int d, input bit dp);
        return slot_raw(pos, pat_tab[d], dp);
    endfunction

    // Pattern lookup by table search; hex letters only when the option is built in.
    function automatic int m_decode(input logic [6:0] seg);
        int limit;
`ifdef DISP_HEX_EN
        limit = 16;
`else
        limit = 10;
`endif
        for (int i = 0; i < limit; i++) begin
            if (pat_tab[i] == seg) return i;
        end
        return -1;
    endfunction

    // Reference model state (what the outputs should be after each edge).
    logic [15:0] m_num;
    logic [3:0]  m_dps;
    logic        m_vld, m_err, m_stale;
    logic [3:0]  m_dig [4];
    logic [3:0]  m_dpb, m_seen;
    bit          m_errf;
    int          m_idle, m_run;
    logic [11:0] m_prev, m_pend_v;
    bit          m_pend;

    initial begin : ref_model
        logic [3:0] sel;
        int d;
        int k;
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) begin
                m_num = 16'h0; m_dps = 4'h0; m_vld = 1'b0; m_err = 1'b0; m_stale = 1'b0;
                for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
                m_dpb = 4'h0; m_seen = 4'h0; m_errf = 1'b0; m_idle = 0;
                m_run = 1; m_prev = 12'hFFF; m_pend_v = 12'hFFF; m_pend = 1'b0;
            end else begin
                // Effects of the slot whose run reached STABLE_CYC on the previous sample.
                m_vld = 1'b0;
                if (m_seen == 4'hF) begin
                    m_num  = {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
                    m_dps  = m_dpb;
                    m_vld  = 1'b1;
                    m_seen = 4'h0;
                    if (!m_errf) m_err = 1'b0;
                    m_errf = 1'b0;
                end
                sel = ~m_pend_v[11:8];
                if (m_pend && $countones(sel) == 1) begin
                    m_idle = 0; m_stale = 1'b0;
                end else if (m_idle >= int'(TIMEOUT)) begin
                    m_stale = 1'b1; m_seen = 4'h0;
                end else begin
                    m_idle++;
                end
                if (m_pend && $countones(sel) > 1) begin
                    m_err = 1'b1; m_errf = 1'b1;
                end else if (m_pend && $countones(sel) == 1) begin
                    k = 0;
                    for (int i = 0; i < 4; i++) if (sel[i]) k = i;
                    d = m_decode(~m_pend_v[6:0]);
                    if (d >= 0) begin
                        if (m_seen == 4'h0) m_errf = 1'b0;
                        m_dig[k]  = 4'(d);
                        m_dpb[k]  = ~m_pend_v[7];
                        m_seen[k] = 1'b1;
                    end else begin
                        m_err = 1'b1; m_errf = 1'b1;
                    end
                end
                // Run length of the bus value sampled at this edge.
                if (disp == m_prev) begin
                    if (m_run < 1000000) m_run++;
                end else begin
                    m_run = 1;
                end
                m_prev   = disp;
                m_pend   = (m_run == int'(STABLE_CYC));
                m_pend_v = disp;
            end
        end
    end

    // Cycle-by-cycle comparison against the model, plus frame pulse counting.
    initial begin : scoreboard
        forever begin
            @(negedge clk);
            if (frame_vld) vld_cnt++;
            if (cmp_en) begin
                check("cyc_num",   32'(num),       32'(m_num));
                check("cyc_dps",   32'(dps),       32'(m_dps));
                check("cyc_vld",   32'(frame_vld), 32'(m_vld));
                check("cyc_err",   32'(seg_err),   32'(m_err));
                check("cyc_stale", 32'(stale),     32'(m_stale));
            end
        end
    end

    task automatic hold(input logic [11:0] v, input int n);
        disp = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        #2;
        disp = 12'hFFF;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    typedef struct {
        logic [15:0] dig;
        logic [3:0]  dp;
        bit          rev;
        bit          pre_en;
        int          pre_pos;
        int          pre_dig;
        logic [15:0] exp_num;
        logic [3:0]  exp_dps;
    } vec_t;

    vec_t vecs [4];

    initial begin : stim
        int p;
        int r;
        logic [3:0] s;

        vecs[0] = '{dig: 16'h9876, dp: 4'b0000, rev: 1'b0, pre_en: 1'b0, pre_pos: 0, pre_dig: 0,
                    exp_num: 16'h9876, exp_dps: 4'b0000};
        vecs[1] = '{dig: 16'h0000, dp: 4'b1111, rev: 1'b1, pre_en: 1'b0, pre_pos: 0, pre_dig: 0,
                    exp_num: 16'h0000, exp_dps: 4'b1111};
        vecs[2] = '{dig: 16'h5183, dp: 4'b1010, rev: 1'b0, pre_en: 1'b1, pre_pos: 2, pre_dig: 7,
                    exp_num: 16'h5183, exp_dps: 4'b1010};
        vecs[3] = '{dig: 16'h2479, dp: 4'b0001, rev: 1'b1, pre_en: 1'b1, pre_pos: 3, pre_dig: 6,
                    exp_num: 16'h2479, exp_dps: 4'b0001};

        // Reset state
        repeat (4) @(negedge clk);
        check("rst_num",   32'(num),       32'h0);
        check("rst_dps",   32'(dps),       32'h0);
        check("rst_vld",   32'(frame_vld), 32'h0);
        check("rst_err",   32'(seg_err),   32'h0);
        check("rst_stale", 32'(stale),     32'h0);
        rstn   = 1'b1;
        cmp_en = 1'b1;

        // Basic frame 1,2,3,4 with dp at pos2
        vld_cnt = 0;
        hold(slot_dig(0, 1, 1'b0), 40);
        hold(slot_dig(1, 2, 1'b0), 40);
        hold(slot_dig(2, 3, 1'b1), 40);
        hold(slot_dig(3, 4, 1'b0), 40);
        check("t1_num",  32'(num),  32'h4321);
        check("t1_dps",  32'(dps),  32'b0100);
        check("t1_vcnt", 32'(vld_cnt), 32'd1);
        check("t1_err",  32'(seg_err), 32'h0);

        // Settle boundary: STABLE_CYC-1 rejected, STABLE_CYC accepted
        hold(12'hFFF, 5);
        vld_cnt = 0;
        for (int i = 0; i < 4; i++) hold(slot_dig(i, 5 + i, 1'b0), int'(STABLE_CYC) - 1);
        hold(12'hFFF, 5);
        check("t2_short_vcnt", 32'(vld_cnt), 32'd0);
        check("t2_short_num",  32'(num),     32'h4321);
        for (int i = 0; i < 4; i++) hold(slot_dig(i, 5 + i, 1'b0), int'(STABLE_CYC));
        hold(12'hFFF, 5);
        check("t2_exact_vcnt", 32'(vld_cnt), 32'd1);
        check("t2_exact_num",  32'(num),     32'h8765);

        // Two selects at once, then a clean frame clears the error
        vld_cnt = 0;
        hold({4'b1100, 1'b1, ~pat_tab[1]}, 20);
        check("t3_err_set", 32'(seg_err), 32'h1);
        check("t3_no_vld",  32'(vld_cnt), 32'd0);
        hold(slot_dig(0, 9, 1'b0), 20);
        hold(slot_dig(1, 0, 1'b0), 20);
        hold(slot_dig(2, 1, 1'b0), 20);
        hold(slot_dig(3, 2, 1'b0), 20);
        hold(12'hFFF, 4);
        check("t3_err_clr", 32'(seg_err), 32'h0);
        check("t3_vcnt",    32'(vld_cnt), 32'd1);
        check("t3_num",     32'(num),     32'h2109);

        // Timeout discards a partial frame
        vld_cnt = 0;
        hold(slot_dig(0, 3, 1'b0), 20);
        hold(slot_dig(1, 4, 1'b0), 20);
        hold(12'hFFF, int'(TIMEOUT) - 10);
        check("t4_not_yet", 32'(stale), 32'h0);
        hold(12'hFFF, 30);
        check("t4_stale",   32'(stale), 32'h1);
        check("t4_num",     32'(num),   32'h2109);
        hold(slot_dig(2, 1, 1'b0), 20);
        check("t4_unstale", 32'(stale), 32'h0);
        hold(slot_dig(3, 2, 1'b0), 20);
        hold(12'hFFF, 4);
        check("t4_partial_gone", 32'(vld_cnt), 32'd0);
        hold(slot_dig(0, 5, 1'b0), 20);
        hold(slot_dig(1, 6, 1'b0), 20);
        hold(12'hFFF, 4);
        check("t4_vcnt", 32'(vld_cnt), 32'd1);
        check("t4_num2", 32'(num),     32'h2165);

        // Hex letter pattern at pos1
        vld_cnt = 0;
        hold(slot_dig(0, 0, 1'b0), 20);
        hold(slot_raw(1, 7'h77, 1'b0), 20);
        hold(slot_dig(2, 0, 1'b0), 20);
        hold(slot_dig(3, 0, 1'b0), 20);
        hold(12'hFFF, 4);
`ifdef DISP_HEX_EN
        check("t5_num",  32'(num),     32'h00A0);
        check("t5_vcnt", 32'(vld_cnt), 32'd1);
        check("t5_err",  32'(seg_err), 32'h0);
`else
        check("t5_num",  32'(num),     32'h2165);
        check("t5_vcnt", 32'(vld_cnt), 32'd0);
        check("t5_err",  32'(seg_err), 32'h1);
`endif

        // Vector table of full frames, including overwrite of an already-seen position
        do_reset();
        for (int v = 0; v < 4; v++) begin
            vld_cnt = 0;
            if (vecs[v].pre_en) hold(slot_dig(vecs[v].pre_pos, vecs[v].pre_dig, 1'b0), 20);
            for (int i = 0; i < 4; i++) begin
                p = vecs[v].rev ? 3 - i : i;
                hold(slot_dig(p, int'(vecs[v].dig[p*4 +: 4]), vecs[v].dp[p]), 20);
            end
            hold(12'hFFF, 4);
            check("vec_num",  32'(num),     32'(vecs[v].exp_num));
            check("vec_dps",  32'(dps),     32'(vecs[v].exp_dps));
            check("vec_vcnt", 32'(vld_cnt), 32'd1);
            check("vec_err",  32'(seg_err), 32'h0);
        end

        // Reset mid-frame: the fourth digit alone must not complete a frame
        hold(slot_dig(0, 1, 1'b0), 20);
        hold(slot_dig(1, 2, 1'b0), 20);
        hold(slot_dig(2, 3, 1'b0), 20);
        #2;
        disp = 12'hFFF;
        rstn = 1'b0;
        #1;
        check("t6_async_num", 32'(num),   32'h0);
        check("t6_async_dps", 32'(dps),   32'h0);
        check("t6_async_err", 32'(seg_err), 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        vld_cnt = 0;
        hold(slot_dig(3, 4, 1'b0), 20);
        hold(12'hFFF, 4);
        check("t6_vcnt", 32'(vld_cnt), 32'd0);
        check("t6_num",  32'(num),     32'h0);

        // Randomized slot stream against the model
        for (int n = 0; n < 250; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 6) begin
`ifdef DISP_HEX_EN
                hold(slot_dig(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), 1'($urandom)),
                     int'($urandom_range(12, 22)));
`else
                hold(slot_dig(int'($urandom_range(0, 3)), int'($urandom_range(0, 9)), 1'($urandom)),
                     int'($urandom_range(12, 22)));
`endif
            end else if (r == 6) begin
                hold(12'hFFF, int'($urandom_range(5, 40)));
            end else if (r == 7) begin
                do s = 4'($urandom); while ($countones(s) < 2);
                hold({~s, 8'($urandom)}, int'($urandom_range(12, 22)));
            end else begin
                hold(slot_raw(int'($urandom_range(0, 3)), 7'($urandom), 1'($urandom)),
                     int'($urandom_range(12, 22)));
            end
        end
        hold(12'hFFF, 30);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
